// File: rtl/addsub_pkg.sv
// Shared types and op decode for the pipelined adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBB = 2'b11
    } addsub_op_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic neg;
    } addsub_flags_t;

    // Returns {invert_b, cin_eff}; SBB borrow-in of 1 means no carry-in.
    function automatic logic [1:0] addsub_ctl(
        input addsub_op_e op,
        input logic       cin
    );
        logic [1:0] r;
        unique case (op)
            ADD: r = 2'b00;
            SUB: r = 2'b11;
            ADC: r = {1'b0, cin};
            SBB: r = {1'b1, ~cin};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SEG_W-bit ripple slice with carry in/out.
module addsub_slice #(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = (SEG_W+1)'(a) + (SEG_W+1)'(b)
                       + (SEG_W+1)'(cin);

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/sub split into STAGES carry-chained slices, valid/ready.
// Signed saturation (in_sat port) exists only when ADDSUB_SAT_EN is defined.
module pipelined_add_sub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
`ifdef ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SEG_W = WIDTH / STAGES;

    logic [STAGES:0]   go;
    logic [STAGES:0]   vld;
    logic [STAGES-1:0] full_q;
    logic [1:0]        ctl;

    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic [TAG_W-1:0] tag_in [STAGES];
`ifdef ADDSUB_SAT_EN
    logic             sat_in [STAGES];
`endif

    addsub_flags_t    flg_q;
    logic [WIDTH-1:0] res_q;
    logic [TAG_W-1:0] tag_q;

    assign ctl       = addsub_ctl(addsub_op_e'(in_op), in_cin);
    assign a_in[0]   = in_a;
    assign b_in[0]   = in_b ^ {WIDTH{ctl[1]}};
    assign c_in[0]   = ctl[0];
    assign s_in[0]   = '0;
    assign tag_in[0] = in_tag;
`ifdef ADDSUB_SAT_EN
    assign sat_in[0] = in_sat;
`endif

    // vld[k] is the valid feeding stage k; vld[STAGES] is the output.
    assign vld = {full_q, in_valid};

    always_comb begin
        go = '0;
        go[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go[k] = !vld[k+1] || go[k+1];
        end
    end

    assign in_ready = go[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= '0;
        end else begin
            full_q <= (full_q & ~go[STAGES-1:0])
                    | (vld[STAGES-1:0] & go[STAGES-1:0]);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [SEG_W-1:0] seg;
        logic             co;
        logic [WIDTH-1:0] s_nx;
        logic             ld;

        assign ld = go[k] && vld[k];

        addsub_slice #(.SEG_W(SEG_W)) u_slice (
            .a    (a_in[k][k*SEG_W +: SEG_W]),
            .b    (b_in[k][k*SEG_W +: SEG_W]),
            .cin  (c_in[k]),
            .sum  (seg),
            .cout (co)
        );

        assign s_nx = s_in[k] | (WIDTH'(seg) << (k * SEG_W));

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic [TAG_W-1:0] t_q;
`ifdef ADDSUB_SAT_EN
            logic             sat_q;
`endif

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    t_q <= '0;
`ifdef ADDSUB_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (ld) begin
                    a_q <= a_in[k];
                    b_q <= b_in[k];
                    s_q <= s_nx;
                    c_q <= co;
                    t_q <= tag_in[k];
`ifdef ADDSUB_SAT_EN
                    sat_q <= sat_in[k];
`endif
                end
            end

            assign a_in[k+1]   = a_q;
            assign b_in[k+1]   = b_q;
            assign s_in[k+1]   = s_q;
            assign c_in[k+1]   = c_q;
            assign tag_in[k+1] = t_q;
`ifdef ADDSUB_SAT_EN
            assign sat_in[k+1] = sat_q;
`endif
        end else begin : g_last
            logic             a_msb;
            logic             ov;
            logic [WIDTH-1:0] res;

            assign a_msb = a_in[k][WIDTH-1];
            assign ov    = (a_msb == b_in[k][WIDTH-1])
                        && (s_nx[WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
            // Clamp toward the sign of A: 0x7F..F or 0x80..0.
            assign res = (sat_in[k] && ov)
                       ? {a_msb, {(WIDTH-1){!a_msb}}} : s_nx;
`else
            assign res = s_nx;
`endif

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    res_q <= '0;
                    flg_q <= '0;
                    tag_q <= '0;
                end else if (ld) begin
                    res_q <= res;
                    flg_q <= '{carry:    co,
                               overflow: ov,
                               zero:     (res == '0),
                               neg:      res[WIDTH-1]};
                    tag_q <= tag_in[k];
                end
            end
        end
    end

    assign out_valid    = vld[STAGES];
    assign out_result   = res_q;
    assign out_carry    = flg_q.carry;
    assign out_overflow = flg_q.overflow;
    assign out_zero     = flg_q.zero;
    assign out_neg      = flg_q.neg;
    assign out_tag      = tag_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH=32, STAGES=2).
// Saturation vectors run only when ADDSUB_SAT_EN is defined.
module tb_pipelined_add_sub;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        in_cin;
`ifdef ADDSUB_SAT_EN
    logic        in_sat;
`endif
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;
    logic        out_neg;
    logic [3:0]  out_tag;
    logic [3:0]  flg;

    int checks = 0;
    int errors = 0;
    int issued;
    int recv;

    pipelined_add_sub #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
        .clock        (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_cin       (in_cin),
`ifdef ADDSUB_SAT_EN
        .in_sat       (in_sat),
`endif
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_tag      (out_tag)
    );

    assign flg = {out_carry, out_overflow, out_zero, out_neg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", name, obs, exp);
        end
    endtask

    // Issue one op with out_ready high; expect its result after 2 edges.
    task automatic one(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic s,
                       input logic [3:0] tag,
                       input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_tag    = tag;
        out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        in_sat    = s;
`else
        if (s) in_cin = cin;
`endif
        #1 check({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check({name, "_vld"}, 32'(out_valid), 32'd1);
        check({name, "_res"}, out_result, er);
        check({name, "_flg"}, 32'(flg), 32'(ef));
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 2'b00;
        in_cin    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        in_sat    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_res", out_result, 32'd0);
        check("rst_flg", 32'(flg), 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1 check("post_rst_rdy", 32'(in_ready), 32'd1);

        one("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 4'h1,
            32'h80000000, 4'b0101);
        one("sub_zero", 2'b01, 32'd5, 32'd5, 1'b0, 1'b0, 4'h2,
            32'h0, 4'b1010);
        one("sub_neg", 2'b01, 32'd0, 32'd1, 1'b0, 1'b0, 4'h3,
            32'hFFFFFFFF, 4'b0001);
        one("adc", 2'b10, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 4'h4,
            32'h0, 4'b1010);
        one("sbb", 2'b11, 32'h0, 32'h0, 1'b1, 1'b0, 4'h5,
            32'hFFFFFFFF, 4'b0001);
        one("add_xseg", 2'b00, 32'h0000FFFF, 32'h1, 1'b0, 1'b0, 4'h6,
            32'h00010000, 4'b0000);
        one("sub_wrap", 2'b01, 32'h80000000, 32'h1, 1'b0, 1'b0, 4'h7,
            32'h7FFFFFFF, 4'b1100);
        one("adc_c0", 2'b10, 32'd10, 32'd20, 1'b0, 1'b0, 4'h8,
            32'd30, 4'b0000);

        // Backpressure: 6 ops, out_ready low for cycles 3..7.
        issued = 0;
        recv   = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid  = (issued < 6);
            in_op     = 2'b00;
            in_a      = 32'(issued);
            in_b      = 32'd100;
            in_cin    = 1'b0;
            in_tag    = 4'(issued);
            out_ready = !(cyc >= 3 && cyc <= 7);
            #1;
            check("bp_rdy", 32'(in_ready),
                  (cyc >= 3 && cyc <= 7) ? 32'd0 : 32'd1);
            if (out_valid) begin
                check("bp_tag", 32'(out_tag), 32'(recv));
                check("bp_res", out_result, 32'(100 + recv));
            end
            if (in_valid && in_ready) issued++;
            if (out_valid && out_ready) recv++;
        end
        check("bp_issued", 32'(issued), 32'd6);
        check("bp_recv", 32'(recv), 32'd6);

        // Asynchronous reset with two ops in flight.
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = 32'd10;
        in_b      = 32'd20;
        in_tag    = 4'h9;
        out_ready = 1'b0;
        @(negedge clk);
        in_tag = 4'hA;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("mid_vld", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_vld", 32'(out_valid), 32'd0);
        check("async_res", out_result, 32'd0);
        check("async_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        one("after_rst", 2'b00, 32'd1, 32'd2, 1'b0, 1'b0, 4'hB,
            32'd3, 4'b0000);

`ifdef ADDSUB_SAT_EN
        one("sat_pos", 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 4'hC,
            32'h7FFFFFFF, 4'b0100);
        one("sat_neg", 2'b01, 32'h80000000, 32'h1, 1'b0, 1'b1, 4'hD,
            32'h80000000, 4'b1101);
        one("nosat_pos", 2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 4'hE,
            32'h80000000, 4'b0101);
        one("nosat_neg", 2'b01, 32'h80000000, 32'h1, 1'b0, 1'b0, 4'hF,
            32'h7FFFFFFF, 4'b1100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
